// File: rtl/imem_boot_loader_if.sv
// Byte-stream channel feeding the boot loader.
//   s_valid : producer has a byte on s_data
//   s_data  : byte payload
//   s_ready : loader can accept a byte this cycle
// master = byte producer, slave = boot loader.
interface imem_boot_loader_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte image, writes it
// as 32-bit words into instruction memory from address 0, and holds the core
// in reset (core_rst = 0) until the image is fully written.
// Optional feature macro: BOOT_CHECKSUM_EN (adds a trailing XOR checksum byte).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   s            : byte-stream slave (s_valid, s_data, s_ready)
//   start        : one-cycle pulse starting a load (honoured in IDLE/RUN/ERR)
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   core_rst     : active-low core reset, high only in RUN
//   done, err    : load completed / load aborted
//   word_count   : words written in the current load
module imem_boot_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_boot_loader_if.slave     s,
   input  logic                  start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int unsigned AW = ADDR_WIDTH;
   localparam int unsigned CW = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN, ERR
`ifdef BOOT_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   // State entered once the last word (or an empty image) is done.
`ifdef BOOT_CHECKSUM_EN
   localparam state_t END_ST = CSUM;
`else
   localparam state_t END_ST = RUN;
`endif

   state_t          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [AW-1:0]   addr_d;
   logic [31:0]     word_d;
   logic [CW-1:0]   wc_d;
   logic [15:0]     len_full;
   logic            xfer;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   // s_ready is a register, so the handshake never depends combinationally on s_valid.
   assign xfer     = s.s_valid && s.s_ready;
   assign len_full = {s.s_data, len_q[7:0]};

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      addr_d     = imem_addr;
      word_d     = imem_wdata;
      wc_d       = word_count;
`ifdef BOOT_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      unique case (state_q)
         IDLE, RUN, ERR: begin
            if (start) begin
               state_d = LEN_LO;
               wc_d    = '0;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = s.s_data;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d = len_full;
               if (len_full == 16'd0) begin
                  state_d = END_ST;
               end else if (32'(len_full) > (32'd1 << AW)) begin
                  state_d = ERR;
               end else begin
                  state_d    = DATA;
                  byte_idx_d = '0;
                  addr_d     = '0;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = s.s_data;
               byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
               csum_d = csum_q ^ s.s_data;
`endif
               if (byte_idx_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            // Address may wrap after the top word; no write follows the wrap.
            addr_d = AW'(imem_addr + 1'b1);
            wc_d   = CW'(word_count + 1'b1);
            if ((32'(word_count) + 32'd1) == 32'(len_q)) state_d = END_ST;
            else                                         state_d = DATA;
         end
`ifdef BOOT_CHECKSUM_EN
         CSUM: begin
            if (xfer) state_d = (s.s_data == csum_q) ? RUN : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         byte_idx_q <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         word_count <= '0;
         s.s_ready  <= 1'b0;
         imem_we    <= 1'b0;
         core_rst   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         imem_addr  <= addr_d;
         imem_wdata <= word_d;
         word_count <= wc_d;
         s.s_ready  <= (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA)
`ifdef BOOT_CHECKSUM_EN
                       || (state_d == CSUM)
`endif
                       ;
         imem_we    <= (state_d == WRITE);
         core_rst   <= (state_d == RUN);
         done       <= (state_d == RUN);
         err        <= (state_d == ERR);
`ifdef BOOT_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued
// as each frame is issued; a forked monitor pops and compares on every imem_we.
module tb_imem_boot_loader;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst, done, err;
   logic [AW:0]   word_count;

   imem_boot_loader_if bus ();

   imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst_n),
      .s          (bus.slave),
      .start      (start),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  frm[$];
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   // Pops one expected write per imem_we cycle.
   task automatic monitor();
      wr_t w;
      forever begin
         @(negedge clk);
         if (rst_n && imem_we) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("imem_addr", 64'(imem_addr), 64'(w.addr));
               check("imem_wdata", 64'(imem_wdata), 64'(w.data));
            end
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the byte was taken.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      while (!bus.s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
      end else begin
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
   endtask

   // Sends frm; appends the XOR of the data bytes when the checksum build is used.
   task automatic send_frame();
      logic [7:0] x = 8'h00;
      for (int i = 0; i < frm.size(); i++) begin
         if (i >= 2) x = x ^ frm[i];
         send_byte(frm[i]);
      end
`ifdef BOOT_CHECKSUM_EN
      send_byte(x);
`endif
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL end_timeout: done/err still 0 after %0d cycles, required 1", n);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, we_seen;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_s_ready", 64'(bus.s_ready), 64'(0));
      check("rst_imem_we", 64'(imem_we), 64'(0));
      check("rst_imem_addr", 64'(imem_addr), 64'(0));
      check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
      check("rst_core_rst", 64'(core_rst), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_word_count", 64'(word_count), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_s_ready", 64'(bus.s_ready), 64'(0));

      // Two-word image
      expect_wr(8'd0, 32'h0000_0013);
      expect_wr(8'd1, 32'h0010_00B3);
      pulse_start();
      check("lenlo_s_ready", 64'(bus.s_ready), 64'(1));
      check("load_core_rst", 64'(core_rst), 64'(0));
      frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
      send_frame();
      wait_end();
      check("t1_done", 64'(done), 64'(1));
      check("t1_core_rst", 64'(core_rst), 64'(1));
      check("t1_err", 64'(err), 64'(0));
      check("t1_word_count", 64'(word_count), 64'(2));
      check("t1_s_ready", 64'(bus.s_ready), 64'(0));

      // Empty image
      pulse_start();
      check("t2_done_cleared", 64'(done), 64'(0));
      check("t2_core_rst_low", 64'(core_rst), 64'(0));
      check("t2_word_count_cleared", 64'(word_count), 64'(0));
      send_byte(8'h00);
      send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
      check("t2_csum_wait", 64'(done), 64'(0));
      send_byte(8'h00);
`endif
      check("t2_done", 64'(done), 64'(1));
      check("t2_core_rst", 64'(core_rst), 64'(1));
      check("t2_word_count", 64'(word_count), 64'(0));

      // Length overflow (257 > 256), then recovery
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);
      check("t3_err", 64'(err), 64'(1));
      check("t3_core_rst", 64'(core_rst), 64'(0));
      check("t3_s_ready", 64'(bus.s_ready), 64'(0));
      check("t3_done", 64'(done), 64'(0));
      pulse_start();
      check("t3_err_cleared", 64'(err), 64'(0));
      expect_wr(8'd0, 32'hDEAD_BEEF);
      frm = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_frame();
      wait_end();
      check("t3_recover_done", 64'(done), 64'(1));
      check("t3_recover_err", 64'(err), 64'(0));

      // Back-pressure: s_valid held high throughout a one-word load
      pulse_start();
      expect_wr(8'd0, 32'h1234_5678);
`ifdef BOOT_CHECKSUM_EN
      frm = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
`else
      frm = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`endif
      idx = 0;
      we_seen = 0;
      repeat (30) begin
         bus.s_valid = 1'b1;
         bus.s_data  = (idx < frm.size()) ? frm[idx] : 8'hAA;
         if (imem_we) begin
            check("t4_ready_in_write", 64'(bus.s_ready), 64'(0));
            we_seen++;
         end
         if (bus.s_ready) idx++;
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      check("t4_bytes_taken", 64'(idx), 64'(frm.size()));
      check("t4_writes", 64'(we_seen), 64'(1));
      check("t4_done", 64'(done), 64'(1));

      // Full-capacity image: 256 words, last write at the top address
      pulse_start();
      frm = '{8'h00, 8'h01};
      for (int i = 0; i < 256; i++) begin
         expect_wr(AW'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
         for (int k = 0; k < 4; k++) frm.push_back(8'(4*i+k));
      end
      send_frame();
      wait_end();
      check("t5_done", 64'(done), 64'(1));
      check("t5_word_count", 64'(word_count), 64'(256));
      check("t5_all_written", 64'(exp_q.size()), 64'(0));

      // Asynchronous reset after 2 of 4 data bytes
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_s_ready", 64'(bus.s_ready), 64'(0));
      check("t6_imem_we", 64'(imem_we), 64'(0));
      check("t6_imem_addr", 64'(imem_addr), 64'(0));
      check("t6_imem_wdata", 64'(imem_wdata), 64'(0));
      check("t6_core_rst", 64'(core_rst), 64'(0));
      check("t6_done", 64'(done), 64'(0));
      check("t6_err", 64'(err), 64'(0));
      check("t6_word_count", 64'(word_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_idle_s_ready", 64'(bus.s_ready), 64'(0));
      pulse_start();
      check("t6_restart_s_ready", 64'(bus.s_ready), 64'(1));
      expect_wr(8'd0, 32'h0403_0201);
      frm = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_frame();
      wait_end();
      check("t6_reload_done", 64'(done), 64'(1));

`ifdef BOOT_CHECKSUM_EN
      // Checksum good, then bad
      pulse_start();
      expect_wr(8'd0, 32'h4433_2211);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h44);
      check("t7_good_done", 64'(done), 64'(1));
      check("t7_good_err", 64'(err), 64'(0));
      pulse_start();
      expect_wr(8'd0, 32'h4433_2211);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h45);
      check("t7_bad_err", 64'(err), 64'(1));
      check("t7_bad_core_rst", 64'(core_rst), 64'(0));
      check("t7_bad_done", 64'(done), 64'(0));
`endif

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
